// File: rtl/lms_weight_update.sv
// Three-tap sign-free LMS weight updater: one sample accepted per 5 cycles,
// each weight updated in its own cycle into a shadow, then all three committed together.
module lms_weight_update #(
    parameter int DW   = 9,
    parameter int FRAC = 4
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 sample_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] xn,
    input  logic signed [DW-1:0] err,
    input  logic        [2:0]    mu_shift,
    input  logic                 w_load,
    input  logic signed [DW-1:0] w0_init,
    input  logic signed [DW-1:0] w1_init,
    input  logic signed [DW-1:0] w2_init,
    output logic signed [DW-1:0] w0,
    output logic signed [DW-1:0] w1,
    output logic signed [DW-1:0] w2,
    output logic                 w_valid,
    output logic        [7:0]    update_count,
    output logic                 sat_flag
);

    localparam int PW  = 2 * DW;
    localparam int SW  = PW + 1;
    localparam int SHW = $clog2(PW) + 1;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 <<< (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(1 <<< (DW - 1)));

    typedef enum logic [2:0] {
        IDLE,
        UPD0,
        UPD1,
        UPD2,
        COMMIT
    } state_t;

    state_t               state_q;
    logic signed [DW-1:0] w_q  [3];
    logic signed [DW-1:0] h_q  [3];
    logic signed [DW-1:0] sh_q [3];
    logic signed [DW-1:0] xn_q;
    logic signed [DW-1:0] err_q;
    logic        [2:0]    mu_q;
    logic                 w_valid_q;
    logic        [7:0]    cnt_q;
    logic                 sat_q;

    logic signed [DW-1:0]  w_sel;
    logic signed [DW-1:0]  h_sel;
    logic signed [PW-1:0]  prod_d;
    logic signed [PW-1:0]  delta_d;
    logic signed [SW-1:0]  sum_d;
    logic        [SHW-1:0] shamt_d;
    logic signed [DW-1:0]  shadow_d;
    logic                  clamp_d;

    // Tap k pairs weight w_k with history h(k+1), i.e. x[n-1-k].
    always_comb begin
        w_sel = w_q[0];
        h_sel = h_q[0];
        case (state_q)
            UPD1: begin
                w_sel = w_q[1];
                h_sel = h_q[1];
            end
            UPD2: begin
                w_sel = w_q[2];
                h_sel = h_q[2];
            end
            default: ;
        endcase
    end

    always_comb begin
        prod_d   = PW'(err_q) * PW'(h_sel);
        shamt_d  = SHW'(FRAC) + SHW'(mu_q);
        delta_d  = prod_d >>> shamt_d;
        sum_d    = SW'(w_sel) + SW'(delta_d);
        shadow_d = sum_d[DW-1:0];
        clamp_d  = 1'b0;
        if (sum_d > SAT_MAX) begin
            shadow_d = SAT_MAX[DW-1:0];
            clamp_d  = 1'b1;
        end else if (sum_d < SAT_MIN) begin
            shadow_d = SAT_MIN[DW-1:0];
            clamp_d  = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q   <= IDLE;
            w_q       <= '{default: '0};
            h_q       <= '{default: '0};
            sh_q      <= '{default: '0};
            xn_q      <= '0;
            err_q     <= '0;
            mu_q      <= '0;
            w_valid_q <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            w_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_load) begin
                        w_q[0] <= w0_init;
                        w_q[1] <= w1_init;
                        w_q[2] <= w2_init;
                        sat_q  <= 1'b0;
                    end else if (sample_valid) begin
                        xn_q    <= xn;
                        err_q   <= err;
                        mu_q    <= mu_shift;
                        state_q <= UPD0;
                    end
                end
                UPD0: begin
                    sh_q[0] <= shadow_d;
                    if (clamp_d) sat_q <= 1'b1;
                    state_q <= UPD1;
                end
                UPD1: begin
                    sh_q[1] <= shadow_d;
                    if (clamp_d) sat_q <= 1'b1;
                    state_q <= UPD2;
                end
                UPD2: begin
                    sh_q[2] <= shadow_d;
                    if (clamp_d) sat_q <= 1'b1;
                    state_q <= COMMIT;
                end
                COMMIT: begin
                    w_q       <= sh_q;
                    h_q[2]    <= h_q[1];
                    h_q[1]    <= h_q[0];
                    h_q[0]    <= xn_q;
                    cnt_q     <= cnt_q + 8'd1;
                    w_valid_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign w0           = w_q[0];
    assign w1           = w_q[1];
    assign w2           = w_q[2];
    assign w_valid      = w_valid_q;
    assign update_count = cnt_q;
    assign sat_flag     = sat_q;

endmodule

// File: tb/tb_lms_weight_update.sv
// Directed bench for lms_weight_update with hand-computed weight trajectories.
module tb_lms_weight_update;

    localparam int DW = 9;

    logic                 Clk = 1'b0;
    logic                 reset;
    logic                 sample_valid;
    logic                 in_ready;
    logic signed [DW-1:0] xn;
    logic signed [DW-1:0] err;
    logic        [2:0]    mu_shift;
    logic                 w_load;
    logic signed [DW-1:0] w0_init;
    logic signed [DW-1:0] w1_init;
    logic signed [DW-1:0] w2_init;
    logic signed [DW-1:0] w0;
    logic signed [DW-1:0] w1;
    logic signed [DW-1:0] w2;
    logic                 w_valid;
    logic        [7:0]    update_count;
    logic                 sat_flag;

    int checks   = 0;
    int failures = 0;
    int ew[3];
    int ecount;

    always #5 Clk = ~Clk;

    lms_weight_update #(.DW(DW), .FRAC(4)) dut (
        .Clk          (Clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .in_ready     (in_ready),
        .xn           (xn),
        .err          (err),
        .mu_shift     (mu_shift),
        .w_load       (w_load),
        .w0_init      (w0_init),
        .w1_init      (w1_init),
        .w2_init      (w2_init),
        .w0           (w0),
        .w1           (w1),
        .w2           (w2),
        .w_valid      (w_valid),
        .update_count (update_count),
        .sat_flag     (sat_flag)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_w(input string tag);
        check({tag, ".w0"}, int'(w0), ew[0]);
        check({tag, ".w1"}, int'(w1), ew[1]);
        check({tag, ".w2"}, int'(w2), ew[2]);
    endtask

    task automatic do_load(input int a, input int b, input int c);
        w_load  = 1'b1;
        w0_init = DW'(a);
        w1_init = DW'(b);
        w2_init = DW'(c);
        tick();
        w_load = 1'b0;
        ew = '{a, b, c};
        check_w("load");
        check("load.sat", int'(sat_flag), 0);
    endtask

    // Accept one sample, then drive junk on every input during the update
    // to show it is ignored, and check the commit timing.
    task automatic do_update(input string tag, input int x, input int e, input int mu);
        xn           = DW'(x);
        err          = DW'(e);
        mu_shift     = 3'(mu);
        sample_valid = 1'b1;
        w_load       = 1'b0;
        tick();
        check({tag, ".busy"}, int'(in_ready), 0);
        w_load   = 1'b1;
        w0_init  = DW'(99);
        w1_init  = DW'(99);
        w2_init  = DW'(99);
        mu_shift = 3'(mu ^ 7);
        err      = ~err;
        xn       = ~xn;
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, ".mid_wv"}, int'(w_valid), 0);
            check_w({tag, ".mid"});
        end
        tick();
        sample_valid = 1'b0;
        w_load       = 1'b0;
        ecount       = (ecount + 1) % 256;
        check({tag, ".wv"}, int'(w_valid), 1);
        check({tag, ".ready"}, int'(in_ready), 1);
        check({tag, ".count"}, int'(update_count), ecount);
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        w_load       = 1'b0;
        xn           = '0;
        err          = '0;
        mu_shift     = '0;
        w0_init      = '0;
        w1_init      = '0;
        w2_init      = '0;
        ew           = '{0, 0, 0};
        ecount       = 0;
        tick();
        tick();
        check_w("rst");
        check("rst.wv", int'(w_valid), 0);
        check("rst.count", int'(update_count), 0);
        check("rst.sat", int'(sat_flag), 0);
        reset = 1'b0;
        check("rst.ready", int'(in_ready), 1);

        // Zero history: weights stay put, history picks up 32
        do_load(16, 0, 0);
        do_update("zh", 32, 32, 0);
        check_w("zh");

        // h1=32: w0 += (16*32)>>>4 = 32
        do_update("adapt", 0, 16, 0);
        ew = '{48, 0, 0};
        check_w("adapt");

        // h2=32 now: w1 += 32
        do_update("hist", 16, 16, 0);
        ew = '{48, 32, 0};
        check_w("hist");

        // h=(16,0,32), mu=2: w0 delta 48>>>6=0, w2 delta 96>>>6=1
        do_load(0, 0, 0);
        do_update("floor", 1, 3, 2);
        ew = '{0, 0, 1};
        check_w("floor");

        // h=(1,16,0), err=-1: floor gives -1 on w0 and w1
        do_update("neg", 255, -1, 0);
        ew = '{-1, -1, 1};
        check_w("neg");

        // h=(255,1,16), err=255: w0 clamps high
        do_load(250, 0, 0);
        do_update("satp", 255, 255, 0);
        ew = '{255, 15, 255};
        check_w("satp");
        check("satp.sat", int'(sat_flag), 1);
        do_load(0, 0, 0);

        // h=(255,255,1), err=-256: w0 and w1 clamp low
        do_load(-250, 0, 0);
        do_update("satn", 0, -256, 0);
        ew = '{-256, -256, -16};
        check_w("satn");
        check("satn.sat", int'(sat_flag), 1);

        // Load wins over a simultaneous sample
        w_load       = 1'b1;
        sample_valid = 1'b1;
        w0_init      = DW'(5);
        w1_init      = DW'(6);
        w2_init      = DW'(7);
        xn           = DW'(50);
        err          = DW'(100);
        tick();
        w_load       = 1'b0;
        sample_valid = 1'b0;
        ew           = '{5, 6, 7};
        check_w("both");
        check("both.sat", int'(sat_flag), 0);
        for (int i = 0; i < 3; i++) begin
            check("both.ready", int'(in_ready), 1);
            tick();
            check("both.wv", int'(w_valid), 0);
        end
        check("both.count", int'(update_count), ecount);

        // Held sample_valid: one accept every 5 cycles
        xn           = '0;
        err          = '0;
        mu_shift     = '0;
        sample_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("held.ready", int'(in_ready), (i % 5 == 4) ? 1 : 0);
            check("held.wv", int'(w_valid), (i % 5 == 4) ? 1 : 0);
        end
        sample_valid = 1'b0;
        ecount += 3;
        check("held.count", int'(update_count), ecount);
        check_w("held");

        // Reset in UPD1 aborts the update
        do_load(1, 2, 3);
        xn           = DW'(10);
        err          = DW'(100);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        ew     = '{0, 0, 0};
        ecount = 0;
        check_w("abort");
        check("abort.ready", int'(in_ready), 1);
        check("abort.wv", int'(w_valid), 0);
        check("abort.count", int'(update_count), 0);
        check("abort.sat", int'(sat_flag), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort.nowv", int'(w_valid), 0);
        end
        check_w("abort.after");

        // Counter wrap 255 -> 0
        xn           = '0;
        err          = '0;
        sample_valid = 1'b1;
        repeat (255 * 5) tick();
        sample_valid = 1'b0;
        ecount = 255;
        check("wrap.255", int'(update_count), 255);
        do_update("wrap", 0, 0, 0);
        check("wrap.zero", int'(update_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
